// File: rtl/serial_add_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module   : serial_add_ctrl_if                                              |
// | Brief    : Requester and full-adder cell signals for serial_add_ctrl.      |
// |            The ovf_out member exists only when SERIAL_ADD_OVF_EN is set.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_out;
`endif

    // Environment side: requester plus the external full-adder cell.
    modport master (
        output start, a_in, b_in, cin_in, fa_s, fa_cout,
        input  fa_a, fa_b, fa_cin, busy, done, sum_out, cout_out
`ifdef SERIAL_ADD_OVF_EN
        , input ovf_out
`endif
    );

    modport slave (
        input  start, a_in, b_in, cin_in, fa_s, fa_cout,
        output fa_a, fa_b, fa_cin, busy, done, sum_out, cout_out
`ifdef SERIAL_ADD_OVF_EN
        , output ovf_out
`endif
    );
endinterface

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : serial_add_ctrl                                                 |
// | Brief    : Bit-serial WIDTH-bit adder sequencer driving one external       |
// |            full-adder cell; optional overflow flag via SERIAL_ADD_OVF_EN.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);
    localparam int                  c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic               w_done;
`ifdef SERIAL_ADD_OVF_EN
    logic               r_ovf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_run       = 1'b0;
        w_last      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_run = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The sum register doubles as the result: fa_s enters at the MSB so that
    // after WIDTH shifts bit i has settled into position i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a_sh  <= bus.a_in;
            r_b_sh  <= bus.b_in;
            r_carry <= bus.cin_in;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_run) begin
            r_sum   <= {bus.fa_s, r_sum[WIDTH-1:1]};
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_carry <= bus.fa_cout;
            r_cnt   <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                r_cout <= bus.fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                // Carry into the MSB versus carry out of it.
                r_ovf  <= r_carry ^ bus.fa_cout;
`endif
            end
        end
    end

    assign bus.fa_a     = w_run & r_a_sh[0];
    assign bus.fa_b     = w_run & r_b_sh[0];
    assign bus.fa_cin   = w_run & r_carry;
    assign bus.busy     = w_run;
    assign bus.done     = w_done;
    assign bus.sum_out  = r_sum;
    assign bus.cout_out = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf_out  = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_add_ctrl                                              |
// | Brief    : Directed vector bench for serial_add_ctrl (WIDTH=8).            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Purely combinational full-adder cell.
    assign bus.fa_s    = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
    assign bus.fa_cout = (bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_cin) | (bus.fa_b & bus.fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        logic c;
        logic ai;
        logic bi;
        int   n;
        int   errs;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a_in   = v.a;
        bus.b_in   = v.b;
        bus.cin_in = v.cin;
        @(negedge clk);
        bus.start  = 1'b0;
        c    = v.cin;
        n    = 0;
        errs = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            if (n < W) begin
                ai = v.a[n];
                bi = v.b[n];
                if (bus.busy !== 1'b1 || bus.fa_a !== ai || bus.fa_b !== bi || bus.fa_cin !== c)
                    errs++;
                c = (ai & bi) | (ai & c) | (bi & c);
            end else begin
                errs++;
            end
            @(negedge clk);
            n++;
        end
        check("latency", n, W);
        check("run_bits", errs, 0);
        check("busy_in_done", bus.busy, 0);
        check("sum", bus.sum_out, v.sum);
        check("cout", bus.cout_out, v.cout);
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", bus.ovf_out, v.ovf);
`endif
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dones;
        logic [8:0] exp9;
        logic [7:0] qa [$];
        logic [7:0] qb [$];
        logic       qc [$];
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ec;

        //           a      b      cin   sum    cout  ovf
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'h55, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b1};

        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.a_in   = '0;
        bus.b_in   = '0;
        bus.cin_in = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum_out, 0);
        check("rst_cout", bus.cout_out, 0);
        check("rst_fa", {bus.fa_a, bus.fa_b, bus.fa_cin}, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", bus.ovf_out, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_op(vecs[i]);

        // Start re-pulsed during RUN with other operands must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = 8'h12; bus.b_in = 8'h34; bus.cin_in = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.a_in = 8'hF0; bus.b_in = 8'h0F; bus.cin_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                dones++;
                check("ignore_sum", {bus.cout_out, bus.sum_out}, 9'h047);
            end
            @(negedge clk);
        end
        check("ignore_done_count", dones, 1);

        // Asynchronous reset partway through an operation.
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = 8'h0F; bus.b_in = 8'h0F; bus.cin_in = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("partial_sum", bus.sum_out, 8'hF0);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_sum", bus.sum_out, 0);
        check("arst_fa", {bus.fa_a, bus.fa_b, bus.fa_cin}, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        check("arst_no_done", dones, 0);
        run_op(vecs[5]);

        // start held high: one accepted op every WIDTH+2 cycles.
        dones = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (bus.done === 1'b1) begin
                dones++;
                check("b2b_busy_in_done", bus.busy, 0);
                if (qa.size() > 0) begin
                    ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
                    exp9 = {1'b0, ea} + {1'b0, eb} + {8'h00, ec};
                    check("b2b_result", {bus.cout_out, bus.sum_out}, exp9);
                end else begin
                    check("b2b_unexpected_done", 1, 0);
                end
            end
            bus.start  = 1'b1;
            bus.a_in   = 8'($urandom);
            bus.b_in   = 8'($urandom);
            bus.cin_in = 1'($urandom);
            if (cyc % (W + 2) == 0) begin
                qa.push_back(bus.a_in); qb.push_back(bus.b_in); qc.push_back(bus.cin_in);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("b2b_done_count", dones, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
